// File: rtl/mlp_window_pkg.sv
// mlp_pkg: shared widths, tap type, FSM states and sample conversion for the MLP front end
package mlp_pkg;
  localparam int N1_DEF = 98;
  localparam int W_X_DEF = 4;
  localparam int W_S_DEF = 8;
  typedef enum logic {FILL, RUN} state_t;
  typedef struct packed {
    logic pol;
    logic [W_X_DEF-1:0] mag;
  } tap_t;
  // widen by one bit so the most negative sample has a representable magnitude
  function automatic tap_t to_sign_mag(input logic [W_S_DEF-1:0] x);
    logic [W_S_DEF:0] a;
    logic [W_S_DEF:0] lim;
    lim = (W_S_DEF+1)'(2**(W_X_DEF-1)-1);
    a = x[W_S_DEF-1] ? -{1'b1, x} : {1'b0, x};
    return '{pol: x[W_S_DEF-1], mag: (a > lim) ? lim[W_X_DEF-1:0] : a[W_X_DEF-1:0]};
  endfunction
endpackage

// File: rtl/mlp_window_if.sv
// mlp_window_if: signed sample stream handshake into the MLP window
interface mlp_window_if #(parameter int W_S = 8);
  logic [W_S-1:0] data;
  logic valid;
  logic ready;
  modport master(output data, valid, input ready);
  modport slave(input data, valid, output ready);
endinterface

// File: rtl/mlp_window_valid_delay.sv
// valid_delay: fixed-latency pulse delay line with async reset and sync clear
module valid_delay #(parameter int LAT = 12) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic din,
  output logic dout
);
  logic [LAT-1:0] sr;
  // one bit per cycle of latency so back-to-back pulses travel independently
  always_ff @(posedge clk or posedge rst)
    if (rst) sr <= '0;
    else sr <= clr ? '0 : LAT'({sr, din});
  assign dout = sr[LAT-1];
endmodule

// File: rtl/mlp_window.sv
// mlp_window: sign-magnitude sliding window feeding the MLP, with an aligned output valid
module mlp_window
  import mlp_pkg::*;
#(
  parameter int N1 = N1_DEF,
  parameter int W_X = W_X_DEF,
  parameter int W_S = W_S_DEF,
  parameter int STRIDE = 1,
  parameter int LAT = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  mlp_window_if.slave          s,
  output logic [N1/2*W_X-1:0]  in_mag,
  output logic [N1/2-1:0]      in_pol,
  output logic                 win_valid,
  output logic                 y_valid
);
  localparam int D = N1 / 2;
  localparam int FW = $clog2(D + 1);
  localparam int SW = $clog2(STRIDE + 1);
  localparam logic [FW-1:0] FILL_LAST = FW'(D - 1);
  localparam logic [SW-1:0] STRIDE_LAST = SW'(STRIDE - 1);
  state_t state_q, state_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [SW-1:0] stride_q, stride_d;
  logic rdy_q, win_d, acc;
  logic [W_S-1:0] sample;
  tap_t [D-1:0] taps;
  assign s.ready = rdy_q & ~flush;
  assign acc = s.valid & s.ready;
  assign sample = s.data;
  // next state, counters and the window-complete strobe
  always_comb begin
    state_d = state_q;
    fill_d = fill_q;
    stride_d = stride_q;
    win_d = 1'b0;
    if (flush) begin
      state_d = FILL;
      fill_d = '0;
      stride_d = '0;
    end else if (acc && state_q == FILL) begin
      fill_d = fill_q + 1'b1;
      win_d = fill_q == FILL_LAST;
      state_d = win_d ? RUN : FILL;
      stride_d = '0;
    end else if (acc) begin
      win_d = stride_q == STRIDE_LAST;
      stride_d = win_d ? '0 : stride_q + 1'b1;
    end
  end
  // control registers; ready rises on the first edge after reset releases
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= FILL;
      fill_q <= '0;
      stride_q <= '0;
      rdy_q <= 1'b0;
      win_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q <= fill_d;
      stride_q <= stride_d;
      rdy_q <= 1'b1;
      win_valid <= win_d;
    end
  // oldest sample falls out of tap 0, newest enters the top tap; taps hold between accepts
  always_ff @(posedge clk or posedge rst)
    if (rst) taps <= '0;
    else if (flush) taps <= '0;
    else if (acc) taps <= {to_sign_mag(sample), taps[D-1:1]};
  for (genvar i = 0; i < D; i++) begin : g_out
    assign in_mag[i*W_X +: W_X] = taps[i].mag;
    assign in_pol[i] = taps[i].pol;
  end
  valid_delay #(.LAT(LAT)) u_dly (
    .clk(clk),
    .rst(rst),
    .clr(flush),
    .din(win_valid),
    .dout(y_valid)
  );
endmodule
